seg7_scan: RTL

//  Time-multiplexed driver for a 4-digit common-anode 7-segment display.

---
 rtl/seg7_scan.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame input
// snapshot, inter-digit ghost blanking, leading-zero blanking and decimal points.
module seg7_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       blank_lz,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST      = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    snap3, snap2, snap1, snap0;
  logic          snap_lz;
  logic [3:0]    snap_dp;

  logic [3:0]    digit;
  logic          digit_blank;
  logic          dark;
  logic [3:0]    nxt_an;
  logic [6:0]    nxt_seg;
  logic          nxt_dp;
  logic          frame_wrap;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign frame_wrap = (idx == 2'd3) && (cnt == LAST);

  always_comb begin
    digit       = snap0;
    digit_blank = 1'b0;
    case (idx)
      2'd0: digit = snap0;
      2'd1: begin
        digit       = snap1;
        digit_blank = snap_lz && (snap3 == 4'd0) && (snap2 == 4'd0) && (snap1 == 4'd0);
      end
      2'd2: begin
        digit       = snap2;
        digit_blank = snap_lz && (snap3 == 4'd0) && (snap2 == 4'd0);
      end
      default: begin
        digit       = snap3;
        digit_blank = snap_lz && (snap3 == 4'd0);
      end
    endcase

    dark = (cnt < BLANK_END) || digit_blank;
    if (dark) begin
      nxt_an  = '1;
      nxt_seg = '1;
      nxt_dp  = 1'b1;
    end else begin
      nxt_an  = ~(4'b0001 << idx);
      nxt_seg = decode(digit);
      nxt_dp  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      snap3   <= '0;
      snap2   <= '0;
      snap1   <= '0;
      snap0   <= '0;
      snap_lz <= 1'b0;
      snap_dp <= '0;
      an      <= '1;
      seg     <= '1;
      dp      <= 1'b1;
    end else if (!en) begin
      // Tracking the inputs while idle means the first frame after enable is current.
      cnt     <= '0;
      idx     <= '0;
      snap3   <= bcd3;
      snap2   <= bcd2;
      snap1   <= bcd1;
      snap0   <= bcd0;
      snap_lz <= blank_lz;
      snap_dp <= dp_mask;
      an      <= '1;
      seg     <= '1;
      dp      <= 1'b1;
    end else begin
      an  <= nxt_an;
      seg <= nxt_seg;
      dp  <= nxt_dp;
      if (cnt == LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (frame_wrap) begin
        snap3   <= bcd3;
        snap2   <= bcd2;
        snap1   <= bcd1;
        snap0   <= bcd0;
        snap_lz <= blank_lz;
        snap_dp <= dp_mask;
      end
    end
  end

endmodule
